// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial converter with valid/ready handshakes on both sides.
// A DATA_WIDTH-bit word is loaded into a shift register and emitted one bit
// per downstream transfer. frame_start / frame_last mark the first and last
// bit of each word so bit-serial consumers can restart per-word state.
// A one-entry holding register lets the next word wait while the current
// word drains, so back-to-back words leave no bubble cycles.
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  frame_start,
    output logic                  frame_last
);

    // Counter wide enough to index every bit of a word.
    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  state_r;
    logic [DATA_WIDTH-1:0]   shreg_r;
    logic [DATA_WIDTH-1:0]   hold_r;
    logic                    hold_valid_r;
    logic [CNT_W-1:0]        bit_cnt_r;

    logic                    accept_s;
    logic                    xfer_s;
    logic                    last_s;
    logic                    shifting_s;

    // Move the shift register one position toward the output end.
    function automatic logic [DATA_WIDTH-1:0] shift_toward_out(
        input logic [DATA_WIDTH-1:0] value
    );
        if (MSB_FIRST) begin
            return {value[DATA_WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, value[DATA_WIDTH-1:1]};
        end
    endfunction

    // Select the bit currently presented at the output end.
    function automatic logic output_bit(input logic [DATA_WIDTH-1:0] value);
        if (MSB_FIRST) begin
            return value[DATA_WIDTH-1];
        end else begin
            return value[0];
        end
    endfunction

    // Handshake and position decode; din_ready depends on a register only.
    always_comb begin
        shifting_s = (state_r == ST_SHIFT);
        din_ready  = ~hold_valid_r;
        accept_s   = din_valid & ~hold_valid_r;
        xfer_s     = shifting_s & dout_ready;
        last_s     = (bit_cnt_r == LAST_CNT);
    end

    // Output decode, driven purely from registered state.
    always_comb begin
        dout_valid  = shifting_s;
        dout        = output_bit(shreg_r);
        frame_start = 1'b0;
        frame_last  = 1'b0;
        if (shifting_s) begin
            frame_start = (bit_cnt_r == CNT_ZERO);
            frame_last  = last_s;
        end else begin
            frame_start = 1'b0;
            frame_last  = 1'b0;
        end
    end

    // Serializer state machine: load, shift, reload from hold or bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {DATA_WIDTH{1'b0}};
            hold_r       <= {DATA_WIDTH{1'b0}};
            hold_valid_r <= 1'b0;
            bit_cnt_r    <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // The holding register is always empty here: SHIFT only
                    // returns to IDLE once nothing is waiting.
                    if (accept_s) begin
                        shreg_r   <= din;
                        bit_cnt_r <= CNT_ZERO;
                        state_r   <= ST_SHIFT;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    if (xfer_s) begin
                        if (last_s) begin
                            if (hold_valid_r) begin
                                // Waiting word takes over immediately.
                                shreg_r      <= hold_r;
                                hold_valid_r <= 1'b0;
                                bit_cnt_r    <= CNT_ZERO;
                                state_r      <= ST_SHIFT;
                            end else if (accept_s) begin
                                // Word arriving on the last-bit edge skips
                                // the holding register to avoid a bubble.
                                shreg_r      <= din;
                                bit_cnt_r    <= CNT_ZERO;
                                state_r      <= ST_SHIFT;
                            end else begin
                                state_r      <= ST_IDLE;
                            end
                        end else begin
                            shreg_r   <= shift_toward_out(shreg_r);
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            state_r   <= ST_SHIFT;
                        end
                    end else begin
                        // Stalled downstream: everything visible holds.
                        state_r <= ST_SHIFT;
                    end

                    // Any accept not consumed by the bypass path is parked.
                    if (accept_s && !(xfer_s && last_s)) begin
                        hold_r       <= din;
                        hold_valid_r <= 1'b1;
                    end else begin
                        hold_valid_r <= hold_valid_r & ~(xfer_s & last_s);
                    end
                end

                default: begin
                    state_r      <= ST_IDLE;
                    hold_valid_r <= 1'b0;
                    bit_cnt_r    <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
// Drives an MSB-first and an LSB-first bit_serializer with identical
// handshake stimulus and compares both against a queue-of-bits reference:
// every accepted word appends its bits (with frame markers) to a queue and
// every downstream transfer pops one.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         dout_ready;

    logic din_ready_m, dout_m, dout_valid_m, frame_start_m, frame_last_m;
    logic din_ready_l, dout_l, dout_valid_l, frame_start_l, frame_last_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending bits as {data, frame_start, frame_last}.
    logic [2:0] q_m[$];
    logic [2:0] q_l[$];
    bit         last_acc;
    bit         fs_seen;
    int         xfer_since;

    bit_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_m), .dout(dout_m), .dout_valid(dout_valid_m),
        .dout_ready(dout_ready), .frame_start(frame_start_m),
        .frame_last(frame_last_m)
    );

    bit_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_l), .dout(dout_l), .dout_valid(dout_valid_l),
        .dout_ready(dout_ready), .frame_start(frame_start_l),
        .frame_last(frame_last_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            q_m.push_back({w[W-1-i], (i == 0), (i == W-1)});
            q_l.push_back({w[i],     (i == 0), (i == W-1)});
        end
    endtask

    // One clock: check outputs at the falling edge, advance model at the rising edge.
    task automatic cycle();
        bit           exp_valid;
        bit           exp_ready;
        bit           acc;
        bit           xf;
        logic [W-1:0] w;
        @(negedge clk);
        exp_valid = (q_m.size() > 0);
        exp_ready = (q_m.size() <= W);
        chk("dout_valid_m", dout_valid_m, exp_valid);
        chk("dout_valid_l", dout_valid_l, exp_valid);
        chk("din_ready_m", din_ready_m, exp_ready);
        chk("din_ready_l", din_ready_l, exp_ready);
        if (exp_valid) begin
            chk("dout_m", dout_m, q_m[0][2]);
            chk("frame_start_m", frame_start_m, q_m[0][1]);
            chk("frame_last_m", frame_last_m, q_m[0][0]);
            chk("dout_l", dout_l, q_l[0][2]);
            chk("frame_start_l", frame_start_l, q_l[0][1]);
            chk("frame_last_l", frame_last_l, q_l[0][0]);
        end else begin
            chk("idle_fs_m", frame_start_m, 1'b0);
            chk("idle_fl_m", frame_last_m, 1'b0);
        end
        chk("fs_fl_excl_m", frame_start_m & frame_last_m, 1'b0);
        chk("fs_fl_excl_l", frame_start_l & frame_last_l, 1'b0);
        if (dout_valid_m && dout_ready) begin
            if (frame_start_m) begin
                if (fs_seen) chk("frame_len", xfer_since, W);
                fs_seen    = 1'b1;
                xfer_since = 1;
            end else begin
                xfer_since++;
            end
        end
        acc = din_valid && exp_ready;
        xf  = exp_valid && dout_ready;
        w   = din;
        @(posedge clk);
        if (xf) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        if (acc) push_word(w);
        last_acc = acc;
        #1;
    endtask

    // Offer a word until accepted; junk is driven while the block is full.
    task automatic send(input logic [W-1:0] w, input bit rnd);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (rnd) dout_ready = ($urandom_range(0, 3) != 0);
            din_valid = 1'b1;
            din = (q_m.size() <= W) ? w : W'($urandom);
            cycle();
            done = last_acc;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input bit rnd);
        din_valid = 1'b0;
        for (int i = 0; i < 400 && q_m.size() > 0; i++) begin
            if (rnd) dout_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        if (q_m.size() > 0) chk("drain_timeout", 32'd0, 32'd1);
        dout_ready = 1'b1;
        cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dout_valid"}, dout_valid_m, 1'b0);
        chk({tag, "_din_ready"}, din_ready_m, 1'b1);
        chk({tag, "_dout"}, dout_m, 1'b0);
        chk({tag, "_frame_start"}, frame_start_m, 1'b0);
        chk({tag, "_frame_last"}, frame_last_m, 1'b0);
        chk({tag, "_dout_valid_l"}, dout_valid_l, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        last_acc   = 1'b0;
        fs_seen    = 1'b0;
        xfer_since = 0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word 0x96 (MSB: 10010110, LSB: 01101001).
        dout_ready = 1'b1;
        send(8'h96, 1'b0);
        drain(1'b0);

        // Back-to-back 0x03 then 0x05 with valid held.
        send(8'h03, 1'b0);
        send(8'h05, 1'b0);
        chk("b2b_held_ready", din_ready_m, 1'b0);
        drain(1'b0);

        // Stall after the first bit of 0xA5: bit 2 (0) and count 1 hold.
        send(8'hA5, 1'b0);
        din_valid = 1'b0;
        cycle();
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_dout", dout_m, 1'b0);
            chk("stall_cnt", dut_m.bit_cnt_r, 32'd1);
        end
        dout_ready = 1'b1;
        drain(1'b0);

        // Last-bit bypass: 0x81 accepted on the edge of 0xFF's last transfer.
        send(8'hFF, 1'b0);
        din_valid = 1'b0;
        while (q_m.size() > 1) cycle();
        send(8'h81, 1'b0);
        chk("bypass_valid", dout_valid_m, 1'b1);
        chk("bypass_fs", frame_start_m, 1'b1);
        chk("bypass_dout", dout_m, 1'b1);
        drain(1'b0);

        // Reset mid-word with a held word present.
        send(8'hC3, 1'b0);
        send(8'h5A, 1'b0);
        din_valid = 1'b0;
        cycle();
        cycle();
        chk("pre_reset_held", din_ready_m, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        q_m.delete();
        q_l.delete();
        fs_seen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(8'h01, 1'b0);
        drain(1'b0);

        // Randomized words, gaps and downstream back-pressure.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                din_valid  = 1'b0;
                dout_ready = ($urandom_range(0, 3) != 0);
                cycle();
            end else begin
                send(W'($urandom), 1'b1);
            end
        end
        drain(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial converter feeding the serial divisibility checker and other bit-serial consumers.
- Accepts DATA_WIDTH-bit words over a valid/ready handshake and emits one bit per transfer on dout.
- Marks frame boundaries so the downstream can restart its residue state per word.
- One-entry holding register allows back-to-back words with no bubble cycles.

Parameters:
DATA_WIDTH, 8, bits per word (>=2)
MSB_FIRST, 1, 1 = MSB first (matches residue-FSM consumers); 0 = LSB first

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
din  input  DATA_WIDTH  parallel word
din_valid  input  1  din holds a word
din_ready  output  1  block can accept a word this cycle
dout  output  1  serial data bit
dout_valid  output  1  dout is a valid bit
dout_ready  input  1  downstream consumes dout this cycle
frame_start  output  1  dout is the first bit of a word
frame_last  output  1  dout is the last bit of a word

Behaviour:
- One clock, asynchronous active-high reset.
- Reset values: dout=0, dout_valid=0, frame_start=0, frame_last=0, din_ready=1. Shift register, bit counter and holding register are cleared; holding-register valid flag is 0.
- Handshakes:
  - Word accept = din_valid & din_ready at a rising edge.
  - Bit transfer = dout_valid & dout_ready at a rising edge.
- din_ready = ~hold_valid. It is combinational from a register only, with no path from din_valid or dout_ready.
- States:
  - IDLE: dout_valid=0.
  - SHIFT: dout_valid=1.
- IDLE + accept: din loads the shift register, bit_cnt=0, state goes to SHIFT. First bit is visible the cycle after the accept (latency 1).
- SHIFT, no transfer (dout_ready=0): dout, frame_start, frame_last and bit_cnt hold their values.
- SHIFT, transfer with bit_cnt < DATA_WIDTH-1: shift by one toward the output end; bit_cnt increments.
- SHIFT, transfer with bit_cnt = DATA_WIDTH-1 (last bit). Priority order:
  1. hold_valid=1: load the shift register from the holding register, clear hold_valid, bit_cnt=0, stay in SHIFT.
  2. Else, simultaneous word accept: load din directly into the shift register, bit_cnt=0, stay in SHIFT. The holding register is bypassed.
  3. Else: go to IDLE.
- SHIFT + accept, not covered by case 2 above: the word goes into the holding register; hold_valid=1.
- Outputs are driven from registered state only:
  - dout = shreg[DATA_WIDTH-1] if MSB_FIRST, else shreg[0].
  - frame_start = dout_valid & (bit_cnt==0).
  - frame_last = dout_valid & (bit_cnt==DATA_WIDTH-1).
- bit_cnt width is clog2(DATA_WIDTH). It never exceeds DATA_WIDTH-1 and wraps to 0 only by reload.
- Sustained throughput: one word per DATA_WIDTH cycles when din_valid=1 and dout_ready=1 continuously. There are no gaps between words.
- din is sampled only at accept. Changes to din while din_ready=0 have no effect.
- Reset mid-word: the partial word and the held word are discarded. Outputs drop to reset values immediately, without waiting for the clock. After release the block is in IDLE.
- Assertions the bench checks:
  - Exactly DATA_WIDTH transfers between consecutive frame_start transfers.
  - frame_start and frame_last are never both 1.

Test Plan:
- Single word, MSB_FIRST=1: accept 0x96 with dout_ready=1 → next 8 cycles dout=1,0,0,1,0,1,1,0. frame_start on cycle 1, frame_last on cycle 8, dout_valid=0 on cycle 9.
- Back-to-back: present 0x03 then 0x05 with din_valid held → 16 consecutive valid cycles 00000011 00000101. din_ready=0 while the second word is held. frame_start on cycles 1 and 9.
- Stall: 0xA5, dout_ready=0 for 3 cycles after bit 2 → dout holds 0 and bit_cnt holds 1 during the stall. The full sequence 10100101 still emerges.
- Last-bit bypass: 0xFF in flight, hold empty, new 0x81 accepted on the same edge as the last-bit transfer → 0x81 starts next cycle with no bubble.
- Reset mid-word: assert reset after 3 bits of 0xC3 with a held word present → dout_valid=0 and din_ready=1 immediately. After release, a new word 0x01 emits 00000001.
- MSB_FIRST=0: accept 0x96 → dout=0,1,1,0,1,0,0,1.
